ar_cla_ctrl: RTL and testbench
==============================

AR_CLA_CTRL -- requirements
Module: ar_cla_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of retry counter.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  2  request per requester (bit i = requester i).
REQ-005 req_ready  out  2  one-hot grant; request i accepted when req_valid[i] & req_ready[i].
REQ-006 req_x / req_y  in  32  operands; [15:0] requester 0, [31:16] requester 1.
REQ-007 req_cin  in  4  2-bit carry-in pair; [1:0] requester 0, [3:2] requester 1.
REQ-008 req_mode  in  2  0 = approximate only, 1 = exact-on-error.
REQ-009 add_x, add_y  out  16 each  operands driven to the shared accuracy-reconfigurable CLA adder.
REQ-010 add_cin  out  2  carry-in pair to the adder.
REQ-011 add_ctl  out  1  adder CTL; 0 = approximate carry select, 1 = exact carry select.
REQ-012 add_sum  in  16  adder sum, combinational from add_* within the same cycle.
REQ-013 add_cout  in  8  adder segment carry pairs.
REQ-014 rsp_valid  out  1  result available.
REQ-015 rsp_ready  in  1  consumer accepts result.
REQ-016 rsp_id  out  1  requester index of result.
REQ-017 rsp_sum  out  16  final sum; rsp_cout  out  2  add_cout[7:6] of final pass.
REQ-018 rsp_retried  out  1  result needed the exact pass.
REQ-019 retry_cnt  out  CNT_W  saturating count of exact passes.

Function
REQ-020 FSM states: IDLE, APPROX, EXACT, DONE; one transaction in flight.
REQ-021 IDLE: req_ready = grant, combinational from req_valid and rr pointer; all other states req_ready = 0.
REQ-022 Arbitration round-robin: one requester valid -> it wins; both valid -> requester != last-granted wins; pointer updates only on acceptance.
REQ-023 On acceptance latch x, y, cin, mode, id; next state APPROX.
REQ-024 add_x/add_y/add_cin driven from latched operands in APPROX and EXACT; 0 in IDLE and DONE.
REQ-025 add_ctl = 0 in APPROX, 1 in EXACT, 0 otherwise.
REQ-026 Error flag in APPROX: err = (add_cout[0]^add_cout[1]) | (add_cout[2]^add_cout[3]) | (add_cout[4]^add_cout[5]).
REQ-027 APPROX, mode = 0 or err = 0: capture add_sum, add_cout[7:6], rsp_retried = 0; next DONE (accept-to-rsp_valid latency 2 cycles).
REQ-028 APPROX, mode = 1 and err = 1: next EXACT; no capture.
REQ-029 EXACT: capture add_sum, add_cout[7:6], rsp_retried = 1; retry_cnt +1 unless at 2^CNT_W-1; next DONE (latency 3 cycles).
REQ-030 DONE: rsp_valid = 1, outputs held stable; rsp_ready = 1 -> IDLE same edge; rsp_ready low -> stay.
REQ-031 rsp_ready while not DONE ignored; rsp_valid never asserted outside DONE.
REQ-032 New request accepted no earlier than the cycle after leaving DONE (no bypass).
REQ-033 Request operand changes after acceptance have no effect on the in-flight transaction.

Reset
REQ-034 rst = 1 at a clock edge -> state IDLE, rr pointer prefers requester 0, captured result/id/retried = 0, retry_cnt = 0, rsp_valid = 0.
REQ-035 rst during APPROX/EXACT/DONE drops the transaction; no response produced, retry_cnt cleared.
REQ-036 While rst = 1, req_ready = 0.

Verification
REQ-037 Req0 mode 0, x=0x1234, y=0x1111, cin=00 -> rsp_valid 2 cycles after accept, rsp_sum=0x2345, rsp_id=0, rsp_retried=0, add_ctl never 1.
REQ-038 Req1 mode 1, stub adder returns add_cout=8'b0000_0001 in APPROX -> EXACT pass with add_ctl=1, rsp_retried=1, retry_cnt=1, latency 3.
REQ-039 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; with only req1 valid, req1 granted back-to-back.
REQ-040 rsp_ready held 0 for 5 cycles in DONE -> rsp_valid, rsp_sum, rsp_id stable; req_ready=00 throughout.
REQ-041 rst asserted one cycle in EXACT -> next cycle IDLE, rsp_valid=0, retry_cnt=0; next request serviced normally.
REQ-042 CNT_W=2, force 5 retries -> retry_cnt saturates at 3.

Source files
------------

// File: rtl/ar_cla_ctrl.sv
// ---------------------------------------------------------------------------
// ar_cla_ctrl
//
// Purpose:
//   Front-end controller for a shared accuracy-reconfigurable carry-lookahead
//   adder. Two requesters compete for the adder through a round-robin arbiter.
//   Each accepted operation first runs an approximate pass. If the requester
//   asked for exact-on-error and the adder reports a carry-select
//   disagreement, one exact pass follows. One transaction is in flight at a
//   time. The result is held until the consumer accepts it.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   req_valid    in   [1:0]  per-requester request strobe
//   req_ready    out  [1:0]  one-hot grant, only driven in IDLE
//   req_x/req_y  in   [31:0] operands, [15:0] requester 0, [31:16] requester 1
//   req_cin      in   [3:0]  carry-in pairs, [1:0] requester 0, [3:2] requester 1
//   req_mode     in   [1:0]  per requester: 0 approximate only, 1 exact-on-error
//   add_x/add_y  out  [15:0] operands to the shared adder
//   add_cin      out  [1:0]  carry-in pair to the adder
//   add_ctl      out         adder carry select: 0 approximate, 1 exact
//   add_sum      in   [15:0] adder sum (combinational from add_*)
//   add_cout     in   [7:0]  adder segment carry pairs
//   rsp_valid    out         result available (DONE only)
//   rsp_ready    in          consumer accepts result
//   rsp_id       out         requester index of the result
//   rsp_sum      out  [15:0] final sum
//   rsp_cout     out  [1:0]  add_cout[7:6] of the final pass
//   rsp_retried  out         result came from the exact pass
//   retry_cnt    out  [CNT_W-1:0] saturating count of exact passes
// ---------------------------------------------------------------------------
module ar_cla_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_x,
  input  logic [31:0]      req_y,
  input  logic [3:0]       req_cin,
  input  logic [1:0]       req_mode,
  output logic [15:0]      add_x,
  output logic [15:0]      add_y,
  output logic [1:0]       add_cin,
  output logic             add_ctl,
  input  logic [15:0]      add_sum,
  input  logic [7:0]       add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_sum,
  output logic [1:0]       rsp_cout,
  output logic             rsp_retried,
  output logic [CNT_W-1:0] retry_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPROX = 2'd1,
    S_EXACT  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A segment pair whose two carries disagree means the approximate carry
  // select guessed wrong for that segment; only the lower three pairs feed
  // a following segment, so the top pair is not part of the error check.
  function automatic logic seg_err(input logic [7:0] cout);
    return (cout[0] ^ cout[1]) | (cout[2] ^ cout[3]) | (cout[4] ^ cout[5]);
  endfunction

  state_e           state_q, state_d;
  logic             last_q, last_d;      // requester granted most recently
  logic [15:0]      x_q, x_d;
  logic [15:0]      y_q, y_d;
  logic [1:0]       cin_q, cin_d;
  logic             mode_q, mode_d;
  logic             id_q, id_d;
  logic [15:0]      sum_q, sum_d;
  logic [1:0]       cout_q, cout_d;
  logic             retried_q, retried_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       grant_s;
  logic             err_s;

  assign err_s = seg_err(add_cout);

  // Round-robin grant: on contention the requester not served last wins.
  always_comb begin
    grant_s = 2'b00;
    case (req_valid)
      2'b01:   grant_s = 2'b01;
      2'b10:   grant_s = 2'b10;
      2'b11:   grant_s = last_q ? 2'b01 : 2'b10;
      default: grant_s = 2'b00;
    endcase
  end

  // Grant is only visible in IDLE and is suppressed while reset is applied.
  always_comb begin
    if ((state_q == S_IDLE) && !rst) begin
      req_ready = grant_s;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Adder drive: latched operands during the two compute states, zero otherwise.
  always_comb begin
    add_x   = 16'h0000;
    add_y   = 16'h0000;
    add_cin = 2'b00;
    add_ctl = 1'b0;
    case (state_q)
      S_APPROX: begin
        add_x   = x_q;
        add_y   = y_q;
        add_cin = cin_q;
        add_ctl = 1'b0;
      end
      S_EXACT: begin
        add_x   = x_q;
        add_y   = y_q;
        add_cin = cin_q;
        add_ctl = 1'b1;
      end
      default: begin
        add_x   = 16'h0000;
        add_y   = 16'h0000;
        add_cin = 2'b00;
        add_ctl = 1'b0;
      end
    endcase
  end

  // Next-state and datapath capture logic.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    x_d       = x_q;
    y_d       = y_q;
    cin_d     = cin_q;
    mode_d    = mode_q;
    id_d      = id_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    retried_d = retried_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s != 2'b00) begin
          // grant_s is one-hot here, so bit 1 alone selects the requester
          id_d    = grant_s[1];
          last_d  = grant_s[1];
          x_d     = grant_s[1] ? req_x[31:16]  : req_x[15:0];
          y_d     = grant_s[1] ? req_y[31:16]  : req_y[15:0];
          cin_d   = grant_s[1] ? req_cin[3:2]  : req_cin[1:0];
          mode_d  = grant_s[1] ? req_mode[1]   : req_mode[0];
          state_d = S_APPROX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_APPROX: begin
        if (mode_q && err_s) begin
          state_d = S_EXACT;
        end else begin
          sum_d     = add_sum;
          cout_d    = add_cout[7:6];
          retried_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_EXACT: begin
        sum_d     = add_sum;
        cout_d    = add_cout[7:6];
        retried_d = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;          // "last was 1" makes requester 0 win first
      x_q       <= 16'h0000;
      y_q       <= 16'h0000;
      cin_q     <= 2'b00;
      mode_q    <= 1'b0;
      id_q      <= 1'b0;
      sum_q     <= 16'h0000;
      cout_q    <= 2'b00;
      retried_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cin_q     <= cin_d;
      mode_q    <= mode_d;
      id_q      <= id_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      retried_q <= retried_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rsp_valid   = (state_q == S_DONE);
  assign rsp_id      = id_q;
  assign rsp_sum     = sum_q;
  assign rsp_cout    = cout_q;
  assign rsp_retried = retried_q;
  assign retry_cnt   = cnt_q;

endmodule

// File: tb/tb_ar_cla_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ar_cla_ctrl
//
// Drives directed transactions into ar_cla_ctrl (CNT_W = 2 so saturation is
// reachable) with a stub adder. A transaction-level model predicts grants,
// latency, adder drive and responses and is compared every cycle; directed
// tasks add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ar_cla_ctrl;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [31:0]   req_x, req_y;
  logic [3:0]    req_cin;
  logic [1:0]    req_mode;
  logic [15:0]   add_x, add_y;
  logic [1:0]    add_cin;
  logic          add_ctl;
  logic [15:0]   add_sum;
  logic [7:0]    add_cout;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [15:0]   rsp_sum;
  logic [1:0]    rsp_cout;
  logic          rsp_retried;
  logic [CW-1:0] retry_cnt;

  // stub adder controls
  logic [15:0]   apx_flip;
  logic [7:0]    cout_apx, cout_ex;

  always #5 clk = ~clk;

  ar_cla_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_cin(req_cin), .req_mode(req_mode),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_ctl(add_ctl),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_retried(rsp_retried),
    .retry_cnt(retry_cnt)
  );

  // Stub adder: exact sum uses cin[0]; the approximate pass corrupts it by apx_flip.
  assign add_sum  = 16'(add_x + add_y + {15'd0, add_cin[0]}) ^ (add_ctl ? 16'h0000 : apx_flip);
  assign add_cout = add_ctl ? cout_ex : cout_apx;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    else            return v;
  endfunction

  // ---------------- transaction-level model + per-cycle compare ------------
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  logic        m_ret  = 1'b0;
  logic        m_id   = 1'b0;
  logic [15:0] m_x, m_y, m_sum, m_exact;
  logic [1:0]  m_cin, m_cout, m_g;
  int          m_k = 0, m_lat = 0, m_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("m_ready_rst", 32'(req_ready), 32'd0);
      m_busy = 1'b0;
      m_last = 1'b1;
      m_cnt  = 0;
    end else if (!m_busy) begin
      m_g = exp_grant(req_valid, m_last);
      chk("m_ready_idle", 32'(req_ready), 32'(m_g));
      chk("m_valid_idle", 32'(rsp_valid), 32'd0);
      chk("m_ctl_idle",   32'(add_ctl),   32'd0);
      chk("m_addx_idle",  32'(add_x),     32'd0);
      chk("m_cnt_idle",   32'(retry_cnt), 32'(m_cnt));
      if (m_g != 2'b00) begin
        m_id    = m_g[1];
        m_last  = m_id;
        m_x     = m_id ? req_x[31:16] : req_x[15:0];
        m_y     = m_id ? req_y[31:16] : req_y[15:0];
        m_cin   = m_id ? req_cin[3:2] : req_cin[1:0];
        m_ret   = req_mode[m_id] &
                  ((cout_apx[0] ^ cout_apx[1]) | (cout_apx[2] ^ cout_apx[3]) |
                   (cout_apx[4] ^ cout_apx[5]));
        m_exact = 16'(m_x + m_y + {15'd0, m_cin[0]});
        m_sum   = m_ret ? m_exact : (m_exact ^ apx_flip);
        m_cout  = m_ret ? cout_ex[7:6] : cout_apx[7:6];
        m_lat   = m_ret ? 3 : 2;
        m_k     = 0;
        m_busy  = 1'b1;
      end
    end else begin
      m_k++;
      chk("m_ready_busy", 32'(req_ready), 32'd0);
      if (m_k < m_lat) begin
        chk("m_valid_early", 32'(rsp_valid), 32'd0);
        chk("m_addx",   32'(add_x),   32'(m_x));
        chk("m_addy",   32'(add_y),   32'(m_y));
        chk("m_addcin", 32'(add_cin), 32'(m_cin));
        chk("m_ctl",    32'(add_ctl), 32'(m_ret && (m_k == 2)));
        chk("m_cnt",    32'(retry_cnt), 32'(m_cnt));
      end else begin
        if ((m_k == m_lat) && m_ret && (m_cnt < 3)) m_cnt++;
        chk("m_valid",   32'(rsp_valid),   32'd1);
        chk("m_sum",     32'(rsp_sum),     32'(m_sum));
        chk("m_id",      32'(rsp_id),      32'(m_id));
        chk("m_cout",    32'(rsp_cout),    32'(m_cout));
        chk("m_retried", 32'(rsp_retried), 32'(m_ret));
        chk("m_ctl_done", 32'(add_ctl),    32'd0);
        chk("m_addx_done", 32'(add_x),     32'd0);
        chk("m_cnt_done", 32'(retry_cnt),  32'(m_cnt));
        if (rsp_ready) m_busy = 1'b0;
      end
    end
  end

  // ---------------- directed stimulus ---------------------------------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_accept(input string nm, output logic [1:0] g);
    logic acc;
    acc = 1'b0;
    g   = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) begin
        acc = 1'b1;
        g   = req_ready;
        break;
      end
    end
    chk({nm, "_accept"}, 32'(acc), 32'd1);
  endtask

  task automatic run_one(input string nm, input logic [1:0] v, input logic [1:0] mode,
                         input logic [15:0] x, input logic [15:0] y, input logic [1:0] cin,
                         input int lat, input logic [15:0] esum, input logic eid,
                         input logic eret);
    logic [1:0] g;
    int n;
    req_valid = v;
    req_mode  = mode;
    req_x     = {x, x};
    req_y     = {y, y};
    req_cin   = {cin, cin};
    wait_accept(nm, g);
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_x     = 32'hDEAD_BEEF;   // late operand changes must not leak in
    req_y     = 32'h5A5A_A5A5;
    req_cin   = 4'hF;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
    chk({nm, "_lat"},     32'(n),           32'(lat));
    chk({nm, "_sum"},     32'(rsp_sum),     32'(esum));
    chk({nm, "_id"},      32'(rsp_id),      32'(eid));
    chk({nm, "_retried"}, 32'(rsp_retried), 32'(eret));
    @(posedge clk); #1;
  endtask

  logic [1:0] g;
  logic [1:0] gseq [6];
  int         s;

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_x = '0; req_y = '0; req_cin = '0;
    req_mode = 2'b00; rsp_ready = 1'b1;
    apx_flip = 16'h0000; cout_apx = 8'h00; cout_ex = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid",   32'(rsp_valid),   32'd0);
    chk("rst_cnt",     32'(retry_cnt),   32'd0);
    chk("rst_sum",     32'(rsp_sum),     32'd0);
    chk("rst_id",      32'(rsp_id),      32'd0);
    chk("rst_retried", 32'(rsp_retried), 32'd0);
    @(posedge clk); #1;

    // plain approximate add, requester 0
    run_one("t_basic", 2'b01, 2'b00, 16'h1234, 16'h1111, 2'b00, 2, 16'h2345, 1'b0, 1'b0);

    // requester 1 exact-on-error, error in pair 0 -> exact pass
    cout_apx = 8'b0000_0001; cout_ex = 8'hC0; apx_flip = 16'h00F0;
    run_one("t_retry", 2'b10, 2'b10, 16'h00FF, 16'h0001, 2'b01, 3, 16'h0101, 1'b1, 1'b1);
    chk("t_retry_cnt", 32'(retry_cnt), 32'd1);
    chk("t_retry_cout", 32'(rsp_cout), 32'd3);

    // exact-on-error but all pairs agree -> approximate result kept
    cout_apx = 8'h3F;
    run_one("t_noerr", 2'b01, 2'b01, 16'h0F0F, 16'h0101, 2'b00, 2, 16'h10E0, 1'b0, 1'b0);

    // approximate-only requester with error in pair 2 -> no retry
    cout_apx = 8'h10;
    run_one("t_mode0err", 2'b10, 2'b01, 16'hFFFF, 16'h0001, 2'b01, 2, 16'h00F1, 1'b1, 1'b0);
    chk("t_mode0err_cnt", 32'(retry_cnt), 32'd1);

    // round-robin: both valid, then only requester 1
    do_reset();
    cout_apx = 8'h00; apx_flip = 16'h0000; req_mode = 2'b00;
    req_x = 32'h0003_0002; req_y = 32'h0001_0001; req_cin = 4'h0;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) req_valid = 2'b10;
      wait_accept("t_rr", g);
      gseq[k] = g;
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    chk("t_rr0", 32'(gseq[0]), 32'd1);
    chk("t_rr1", 32'(gseq[1]), 32'd2);
    chk("t_rr2", 32'(gseq[2]), 32'd1);
    chk("t_rr3", 32'(gseq[3]), 32'd2);
    chk("t_rr4", 32'(gseq[4]), 32'd2);
    chk("t_rr5", 32'(gseq[5]), 32'd2);
    repeat (4) @(posedge clk);
    #1;

    // back-pressure: result held for 5 cycles with both requesters waiting
    rsp_ready = 1'b0;
    req_valid = 2'b01; req_mode = 2'b00;
    req_x = 32'h0000_0042; req_y = 32'h0000_0001; req_cin = 4'h0;
    wait_accept("t_stall", g);
    @(posedge clk); #1;
    req_valid = 2'b11;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        s = 1;
        break;
      end
    end
    chk("t_stall_seen", 32'(s), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t_stall_valid", 32'(rsp_valid), 32'd1);
      chk("t_stall_sum",   32'(rsp_sum),   32'h0043);
      chk("t_stall_id",    32'(rsp_id),    32'd0);
      chk("t_stall_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 1'b1;
    @(posedge clk); #1;

    // reset while in EXACT drops the transaction and clears retry_cnt
    cout_apx = 8'h01; cout_ex = 8'h00; apx_flip = 16'h0F00;
    run_one("t_pre", 2'b01, 2'b01, 16'h0010, 16'h0020, 2'b00, 3, 16'h0030, 1'b0, 1'b1);
    chk("t_pre_cnt", 32'(retry_cnt), 32'd1);
    req_valid = 2'b01; req_mode = 2'b01;
    req_x = 32'h0000_0005; req_y = 32'h0000_0006; req_cin = 4'h0;
    wait_accept("t_rstx", g);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    chk("t_rstx_ctl", 32'(add_ctl), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t_rstx_valid", 32'(rsp_valid), 32'd0);
    chk("t_rstx_cnt",   32'(retry_cnt), 32'd0);
    @(posedge clk); #1;
    cout_apx = 8'h00; apx_flip = 16'h0000;
    run_one("t_after", 2'b01, 2'b00, 16'h0100, 16'h0200, 2'b01, 2, 16'h0301, 1'b0, 1'b0);

    // saturation of the 2-bit retry counter
    do_reset();
    cout_apx = 8'h04; cout_ex = 8'h40; apx_flip = 16'h0001;
    for (int i = 1; i <= 5; i++) begin
      run_one("t_sat", 2'b10, 2'b10, 16'h1000, 16'h0001, 2'b00, 3, 16'h1001, 1'b1, 1'b1);
      chk("t_sat_cnt", 32'(retry_cnt), 32'((i < 3) ? i : 3));
    end
    chk("t_sat_final", 32'(retry_cnt), 32'd3);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
